// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample loading path.
package audio_pkg;

  localparam int unsigned SAMPLE_W = 16;
  localparam int unsigned BYTE_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LO,
    WAIT_HI,
    WRITE,
    DONE,
    WAIT_CK
  } loader_state_t;

endpackage

// File: rtl/audio_sample_loader_strobe_sync.sv
// Multi-stage synchronizer for an asynchronous pin with a registered
// one-cycle rising-edge pulse; latency from pin rise is SYNC_STAGES+1 edges.
module strobe_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_i,
  output logic pulse_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   pulse_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe_i};
      prev_q  <= sync_q[SYNC_STAGES-1];
      pulse_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/audio_sample_loader.sv
// Loads N_SAMPLES 16-bit little-endian samples from the Arduino byte link into
// sample RAM. Optional trailing XOR checksum: AUDIO_SAMPLE_LOADER_CHECKSUM_EN.
module audio_sample_loader
  import audio_pkg::*;
#(
  parameter int unsigned N_SAMPLES   = 256,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                read_arduino_in,
  input  logic [BYTE_W-1:0]   data,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [SAMPLE_W-1:0] mem_wdata,
  output logic                busy,
  output logic                flag,
  output logic                err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  loader_state_t       state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [BYTE_W-1:0]   lo_q, lo_d;
  logic [SAMPLE_W-1:0] wdata_q, wdata_d;
  logic                evt;

`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
  localparam loader_state_t END_STATE = WAIT_CK;
  logic [BYTE_W-1:0] ck_q, ck_d;
  logic              err_q, err_d;
`else
  localparam loader_state_t END_STATE = DONE;
`endif

  strobe_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk_i    (clk),
    .rst_i    (rst),
    .strobe_i (read_arduino_in),
    .pulse_o  (evt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      lo_q    <= '0;
      wdata_q <= '0;
`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
      ck_q    <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      lo_q    <= lo_d;
      wdata_q <= wdata_d;
`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
      ck_q    <= ck_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    lo_d    = lo_q;
    wdata_d = wdata_q;
`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
    ck_d    = ck_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = WAIT_LO;
          addr_d  = '0;
`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
          ck_d    = '0;
          err_d   = 1'b0;
`endif
        end
      end
      WAIT_LO: begin
        if (evt) begin
          lo_d    = data;
          state_d = WAIT_HI;
`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
          ck_d    = ck_q ^ data;
`endif
        end
      end
      WAIT_HI: begin
        if (evt) begin
          wdata_d = {data, lo_q};
          state_d = WRITE;
`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
          ck_d    = ck_q ^ data;
`endif
        end
      end
      WRITE: begin
        // Address saturates at the last sample instead of wrapping.
        if (addr_q < LAST_ADDR) begin
          addr_d  = addr_q + 1'b1;
          state_d = WAIT_LO;
        end else begin
          state_d = END_STATE;
        end
      end
`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
      WAIT_CK: begin
        if (evt) begin
          err_d   = (data != ck_q);
          state_d = DONE;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign mem_we    = (state_q == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q == WAIT_LO) || (state_q == WAIT_HI) ||
                     (state_q == WRITE)   || (state_q == WAIT_CK);
  assign flag      = (state_q == DONE);
`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
  assign err       = err_q;
`else
  assign err       = 1'b0;
`endif

endmodule

// File: tb/tb_audio_sample_loader.sv
// Directed bench for audio_sample_loader: one N_SAMPLES=4 and one N_SAMPLES=1 instance.
module tb_audio_sample_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start4 = 1'b0, strb4 = 1'b0;
  logic        start1 = 1'b0, strb1 = 1'b0;
  logic [7:0]  dat4 = '0, dat1 = '0;

  logic        we4, busy4, flag4, err4;
  logic [7:0]  addr4;
  logic [15:0] wdata4;
  logic        we1, busy1, flag1, err1;
  logic [7:0]  addr1;
  logic [15:0] wdata1;

  int unsigned total = 0;
  int unsigned bad   = 0;

  int unsigned nw4 = 0, nw1 = 0;
  logic [7:0]  alog4 [0:15];
  logic [15:0] dlog4 [0:15];
  logic [7:0]  alog1 [0:15];
  logic [15:0] dlog1 [0:15];
  logic        pend1 = 1'b0;
  logic        flag_after1 = 1'b0, busy_after1 = 1'b1;

  always #5 clk = ~clk;

  audio_sample_loader #(.N_SAMPLES(4), .ADDR_W(8), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .read_arduino_in(strb4), .data(dat4),
    .mem_we(we4), .mem_addr(addr4), .mem_wdata(wdata4),
    .busy(busy4), .flag(flag4), .err(err4)
  );

  audio_sample_loader #(.N_SAMPLES(1), .ADDR_W(8), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .read_arduino_in(strb1), .data(dat1),
    .mem_we(we1), .mem_addr(addr1), .mem_wdata(wdata1),
    .busy(busy1), .flag(flag1), .err(err1)
  );

  always @(negedge clk) begin
    if (we4 === 1'b1 && nw4 < 16) begin
      alog4[nw4] = addr4;
      dlog4[nw4] = wdata4;
      nw4 = nw4 + 1;
    end
    if (pend1) begin
      flag_after1 = flag1;
      busy_after1 = busy1;
    end
    pend1 = (we1 === 1'b1);
    if (we1 === 1'b1 && nw1 < 16) begin
      alog1[nw1] = addr1;
      dlog1[nw1] = wdata1;
      nw1 = nw1 + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic send4(input logic [7:0] b, input int hi);
    @(negedge clk);
    dat4  = b;
    strb4 = 1'b1;
    cycles(hi);
    strb4 = 1'b0;
    cycles(5);
  endtask

  task automatic send1(input logic [7:0] b);
    @(negedge clk);
    dat1  = b;
    strb1 = 1'b1;
    cycles(5);
    strb1 = 1'b0;
    cycles(5);
  endtask

  task automatic go4;
    @(negedge clk); start4 = 1'b1;
    @(negedge clk); start4 = 1'b0;
  endtask

  task automatic go1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
  endtask

  initial begin
    cycles(3);
    rst = 1'b0;
    cycles(2);
    check("rst_we",    {31'd0, we4},    32'd0);
    check("rst_addr",  {24'd0, addr4},  32'd0);
    check("rst_wdata", {16'd0, wdata4}, 32'd0);
    check("rst_busy",  {31'd0, busy4},  32'd0);
    check("rst_flag",  {31'd0, flag4},  32'd0);
    check("rst_err",   {31'd0, err4},   32'd0);

    send4(8'hA5, 5);
    send4(8'h5A, 5);
    send1(8'h11);
    send1(8'h22);
    check("idle_nowrite4", nw4, 32'd0);
    check("idle_nowrite1", nw1, 32'd0);
    check("idle_busy",     {31'd0, busy4}, 32'd0);

    // N=1 single sample
    go1;
    check("n1_busy", {31'd0, busy1}, 32'd1);
    send1(8'h34);
    send1(8'h12);
    check("n1_nw",    nw1, 32'd1);
    check("n1_addr",  {24'd0, alog1[0]}, 32'd0);
    check("n1_wdata", {16'd0, dlog1[0]}, 32'h1234);
`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
    check("n1_flag_next", {31'd0, flag_after1}, 32'd0);
    check("n1_busy_next", {31'd0, busy_after1}, 32'd1);
    send1(8'h26);
    check("ck_ok_err",  {31'd0, err1},  32'd0);
    check("ck_ok_flag", {31'd0, flag1}, 32'd1);
    go1;
    send1(8'h34);
    send1(8'h12);
    send1(8'h27);
    check("ck_bad_err",  {31'd0, err1},  32'd1);
    check("ck_bad_flag", {31'd0, flag1}, 32'd1);
`else
    check("n1_flag_next", {31'd0, flag_after1}, 32'd1);
    check("n1_busy_next", {31'd0, busy_after1}, 32'd0);
    check("n1_err",       {31'd0, err1},        32'd0);
`endif

    // N=4 full buffer, first byte on a long-held strobe, start while busy
    go4;
    check("n4_busy_start", {31'd0, busy4}, 32'd1);
    check("n4_addr_start", {24'd0, addr4}, 32'd0);
    send4(8'h00, 20);
    send4(8'h01, 5);
    check("hold_one_byte", nw4, 32'd1);
    go4;
    for (int b = 2; b < 8; b++) send4(8'(b), 5);
    check("n4_nw", nw4, 32'd4);
    check("n4_a0", {24'd0, alog4[0]}, 32'd0);
    check("n4_d0", {16'd0, dlog4[0]}, 32'h0100);
    check("n4_a1", {24'd0, alog4[1]}, 32'd1);
    check("n4_d1", {16'd0, dlog4[1]}, 32'h0302);
    check("n4_a2", {24'd0, alog4[2]}, 32'd2);
    check("n4_d2", {16'd0, dlog4[2]}, 32'h0504);
    check("n4_a3", {24'd0, alog4[3]}, 32'd3);
    check("n4_d3", {16'd0, dlog4[3]}, 32'h0706);
    check("n4_addr_end", {24'd0, addr4}, 32'd3);
`ifdef AUDIO_SAMPLE_LOADER_CHECKSUM_EN
    send4(8'h00, 5);
`endif
    check("n4_flag", {31'd0, flag4}, 32'd1);
    check("n4_busy", {31'd0, busy4}, 32'd0);
    check("n4_err",  {31'd0, err4},  32'd0);
    send4(8'h55, 5);
    check("ninth_nowrite", nw4, 32'd4);
    check("ninth_addr", {24'd0, addr4}, 32'd3);

    // Reset mid-load after three bytes
    go4;
    check("restart_flag", {31'd0, flag4}, 32'd0);
    send4(8'h10, 5);
    send4(8'h11, 5);
    send4(8'h12, 5);
    check("mid_nw",   nw4, 32'd5);
    check("mid_addr", {24'd0, addr4}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_we",    {31'd0, we4},    32'd0);
    check("mid_rst_addr",  {24'd0, addr4},  32'd0);
    check("mid_rst_wdata", {16'd0, wdata4}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy4},  32'd0);
    check("mid_rst_flag",  {31'd0, flag4},  32'd0);
    check("mid_rst_err",   {31'd0, err4},   32'd0);
    cycles(2);
    rst = 1'b0;
    cycles(2);
    send4(8'h77, 5);
    check("post_rst_idle", nw4, 32'd5);
    go4;
    send4(8'hAA, 5);
    send4(8'hBB, 5);
    check("again_nw",    nw4, 32'd6);
    check("again_addr",  {24'd0, alog4[5]}, 32'd0);
    check("again_wdata", {16'd0, dlog4[5]}, 32'hBBAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
